uart_rx_oversample: RTL and testbench
=====================================

# uart_rx_oversample

Oversampling UART receiver. It recovers 8N1 frames from an asynchronous serial line by sampling at 16x the baud rate and taking each bit at mid-bit. It validates the start and stop bits and presents each byte on a valid/ready handshake with framing-error and overrun flags. It is the receive end for the team's UART transmitter and replaces the single-rate receiver path in UART subsystems that need robust reception.

## Interface
- CLK_FREQ, 1000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line rate in baud.
- OVERSAMPLE, 16: ticks per bit; must be even and at least 4.
- Derived DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division, minimum 1. The default is 6, so one bit lasts 96 clk.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset; clock clk.
- rx  in  1  asynchronous serial input; idle level is high.
- rx_data  out  8  received byte; held stable while rx_valid=1.
- rx_valid  out  1  byte available; held until accepted.
- rx_ready  in  1  consumer accepts the byte when rx_valid=1 and rx_ready=1 on the same edge.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- overrun  out  1  one-cycle pulse when a good frame completes while the held byte is unaccepted.

## Operation
- rx passes through a 2-FF synchronizer. Both flops reset to 1; all logic below uses the synchronized value rxs.
- Tick generator: counts 0..DIV-1 and pulses tick when the count is DIV-1. It is forced to 0 in the cycle the start edge is detected, so sampling is phase-aligned to the frame.
- FSM states:
  - IDLE: on a falling edge of rxs (previous 1, current 0), clear the tick and sample counters and go to START.
  - START: on tick number OVERSAMPLE/2, sample rxs. If 0, go to DATA; if 1, treat it as a glitch and return to IDLE with no outputs.
  - DATA: every OVERSAMPLE ticks, sample rxs into a shift register, LSB first. After 8 bits, go to STOP.
  - STOP: after OVERSAMPLE more ticks, sample rxs. If 1, the frame is good; if 0, pulse frame_err and discard the byte. Return to IDLE in either case. Because IDLE needs a 1→0 edge, a held break (rx=0) never retriggers.
- Good-frame handling:
  - If rx_valid=0, or rx_valid=1 with rx_ready=1 on the same edge: load rx_data and set rx_valid=1.
  - Otherwise: pulse overrun and drop the new byte; rx_data and rx_valid are unchanged.
- Handshake:
  - rx_valid clears on an accept edge unless a good frame loads on that same edge.
  - rx_data must not change while rx_valid=1 and no accept occurs.
- Reset:
  - rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, state IDLE, counters 0, synchronizer 1.
  - Reset mid-frame aborts the frame and discards the partial byte.

## Timing
- Pin-to-detect latency is 2 clk (synchronizer).
- Mid-start sample: OVERSAMPLE/2*DIV clk after the detect cycle (48 clk at defaults).
- Data bit k (k=0..7) sample: (OVERSAMPLE/2 + (k+1)*OVERSAMPLE)*DIV clk after detect.
- Stop sample: (OVERSAMPLE/2 + 9*OVERSAMPLE)*DIV clk after detect (912 clk at defaults).
- rx_valid, frame_err and overrun are registered. They assert on the edge at which the stop-sample tick is processed.
- frame_err and overrun are exactly 1 clk wide.
- Back-to-back frames (stop bit directly followed by start) are received without loss. FSM is back in IDLE half a bit before the next start edge.
- Baud tolerance is about ±4% cumulative at OVERSAMPLE=16. No resynchronization occurs inside a frame.

## Structure
- uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, STOP);
  - the default CLK_FREQ, BAUD_RATE and OVERSAMPLE;
  - a function computing DIV with the minimum-1 clamp.
- Sub-module uart_baud_tick is the parameterized tick generator with a synchronous restart input, reusable by the transmitter.
- The synchronizer, FSM, shift register and output register stay in uart_rx_oversample.

## Test plan
- Defaults, rx_ready=1, drive the 0xA5 8N1 frame at 96 clk/bit → rx_valid high for 1 clk with rx_data=0xA5, 914 clk after the pin falling edge; frame_err=0.
- rx low for 30 clk then high (glitch shorter than 48 clk) → FSM returns to IDLE; no rx_valid, frame_err or overrun for 2000 clk.
- Frame 0x3C with the stop bit driven 0 → frame_err 1-clk pulse at stop sample; rx_valid stays 0; holding rx=0 for 5 bit times produces no further frame.
- rx_ready=0, send 0x11 then 0x22 back-to-back → rx_data=0x11 and rx_valid held, overrun pulse at the 0x22 stop sample. Then raise rx_ready for 1 clk → rx_valid=0 next cycle.
- Assert rst for 1 clk during bit 3 of frame 0xFF, then send 0x5A → only 0x5A delivered; all outputs 0 in the cycle after reset.
- rx_ready=0, send 0x00 then 0xFF, and pulse rx_ready exactly on the 0xFF stop-sample edge → 0x00 accepted, rx_data=0xFF with rx_valid still 1, no overrun.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default line parameters and
// the clock-divider calculation used by the tick generators.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  localparam int DEF_CLK_FREQ   = 1_000_000;
  localparam int DEF_BAUD_RATE  = 9600;
  localparam int DEF_OVERSAMPLE = 16;

  // Clocks per oversample tick, never below 1 so the divider always runs.
  function automatic int calc_div(input int clk_freq, input int baud_rate,
                                  input int oversample);
    int div;
    div = clk_freq / (baud_rate * oversample);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick on the last
// count. restart forces the count to 0 so ticks align to a new frame.
module uart_baud_tick #(
  parameter int DIV = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    cnt_d = cnt_q + CW'(1);
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  assign tick = !restart && (cnt_q == LAST);

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver sampling at OVERSAMPLE x baud, mid-bit decision, with a
// valid/ready output holding register plus framing-error and overrun pulses.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD_RATE  = DEF_BAUD_RATE,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int            DIV       = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int            TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

  logic            rx_meta_q, rxs_q, rxs_prev_q;
  rx_state_e       state_q, state_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            restart, tick, good_frame, accept;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  // Synchronizer and edge-history flops idle high so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    restart     = 1'b0;
    good_frame  = 1'b0;
    accept      = rx_valid_q && rx_ready;
    rx_valid_d  = rx_valid_q && !accept;

    unique case (state_q)
      IDLE: begin
        // Only a 1->0 transition starts a frame, so a held break is ignored.
        if (rxs_prev_q && !rxs_q) begin
          restart    = 1'b1;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt_q == HALF_LAST) begin
            tick_cnt_d = '0;
            state_d    = rxs_q ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            shift_d    = {rxs_q, shift_q[7:1]};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d  = '0;
            state_d     = IDLE;
            good_frame  = rxs_q;
            frame_err_d = !rxs_q;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A byte accepted on this same edge frees the holding register.
    if (good_frame) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: directed frame table, hand-written corner
// sequences and random frames checked against an event-level reference model.
module tb_uart_rx_oversample;

  localparam int DIV     = 1_000_000 / (9600 * 16);
  localparam int BIT_CLK = 16 * DIV;
  // Edge after the pin edge at which the stop-sample result is registered.
  localparam int LAT     = 2 + (16 / 2 + 9 * 16) * DIV;

  localparam int K_LOAD = 1;
  localparam int K_FERR = 2;
  localparam int K_OVR  = 3;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         exp_kind;
    logic [7:0] exp_data;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int  cyc = 0;
  int  tests = 0;
  int  failed = 0;
  int  last_e0 = 0;
  bit  model_held = 1'b0;
  ev_t exp_q[$];
  ev_t obs_q[$];
  vec_t vecs[7];

  uart_rx_oversample dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Observer: logs every byte load and every error pulse with its edge index.
  logic       mon_prev_valid = 1'b0;
  logic [7:0] mon_prev_data  = 8'h00;
  always @(posedge clk) begin
    ev_t e;
    #1;
    e.cyc  = cyc;
    e.data = 8'h00;
    if (!rst && mon_prev_valid && !rx_ready) begin
      check("hold_data", rx_data, mon_prev_data);
      check("hold_valid", rx_valid, 1);
    end
    if (rx_valid && (!mon_prev_valid || rx_ready)) begin
      e.kind = K_LOAD;
      e.data = rx_data;
      obs_q.push_back(e);
    end
    if (frame_err) begin
      e.kind = K_FERR;
      e.data = 8'h00;
      obs_q.push_back(e);
    end
    if (overrun) begin
      e.kind = K_OVR;
      e.data = 8'h00;
      obs_q.push_back(e);
    end
    mon_prev_valid = rx_valid;
    mon_prev_data  = rx_data;
  end

  // Drives one 8N1 frame; rx is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok);
    logic [9:0] bits;
    bits = {stop_ok, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = bits[i];
      if (i == 0) last_e0 = cyc + 1;
      repeat (BIT_CLK - 1) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx = 1'b1;
    repeat (n - 1) @(negedge clk);
  endtask

  // Reference model: outcome of a frame follows from its stop bit and whether
  // the holding register is free (or being accepted) at the stop sample.
  task automatic model_frame(input int e0, input logic [7:0] d, input bit stop_ok,
                             input bit ready_at_stop);
    ev_t e;
    e.cyc  = e0 + LAT;
    e.data = 8'h00;
    if (!stop_ok) begin
      e.kind = K_FERR;
    end else if (!model_held || ready_at_stop) begin
      e.kind     = K_LOAD;
      e.data     = d;
      model_held = 1'b1;
    end else begin
      e.kind = K_OVR;
    end
    exp_q.push_back(e);
  endtask

  task automatic compare_queues(input string tag);
    int n;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_cycle"}, obs_q[i].cyc, exp_q[i].cyc);
      check({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
      check({tag, "_data"}, obs_q[i].data, exp_q[i].data);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  gap;
    bit  ok;
    logic [7:0] d;

    vecs[0] = '{8'hA5, 1'b1, K_LOAD, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, K_FERR, 8'h00};
    vecs[2] = '{8'h00, 1'b1, K_LOAD, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, K_LOAD, 8'hFF};
    vecs[4] = '{8'h80, 1'b1, K_LOAD, 8'h80};
    vecs[5] = '{8'h01, 1'b0, K_FERR, 8'h00};
    vecs[6] = '{8'h7E, 1'b1, K_LOAD, 8'h7E};

    rst = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    rst = 1'b0;
    idle(50);
    obs_q.delete();

    // Directed table, consumer always ready.
    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].data, vecs[v].stop_ok);
      idle(100);
      check("vec_events", obs_q.size(), 1);
      if (obs_q.size() >= 1) begin
        check("vec_kind", obs_q[0].kind, vecs[v].exp_kind);
        check("vec_data", obs_q[0].data, vecs[v].exp_data);
        check("vec_latency", obs_q[0].cyc - last_e0, LAT);
      end
      check("vec_valid_dropped", rx_valid, 0);
      check("vec_ferr_low", frame_err, 0);
      obs_q.delete();
    end

    // Short low glitch never becomes a frame.
    @(negedge clk);
    rx = 1'b0;
    repeat (29) @(negedge clk);
    idle(2000);
    compare_queues("glitch");

    // Bad stop bit then a held break: one frame error only.
    send_frame(8'h3C, 1'b0);
    model_frame(last_e0, 8'h3C, 1'b0, 1'b1);
    repeat (5 * BIT_CLK) @(negedge clk);
    idle(1000);
    compare_queues("break");
    check("break_valid", rx_valid, 0);

    // Overrun: consumer stalled across two back-to-back frames.
    rx_ready = 1'b0;
    model_held = 1'b0;
    send_frame(8'h11, 1'b1);
    model_frame(last_e0, 8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1);
    model_frame(last_e0, 8'h22, 1'b1, 1'b0);
    idle(200);
    compare_queues("overrun");
    check("overrun_data_held", rx_data, 8'h11);
    check("overrun_valid_held", rx_valid, 1);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    model_held = 1'b0;
    check("accept_clears_valid", rx_valid, 0);
    idle(50);

    // Accept on exactly the stop-sample edge of the next frame.
    send_frame(8'h00, 1'b1);
    model_frame(last_e0, 8'h00, 1'b1, 1'b0);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        int target;
        @(negedge clk);
        target = cyc + LAT;
        for (int w = 0; w < 3 * LAT && cyc < target; w++) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    model_frame(last_e0, 8'hFF, 1'b1, 1'b1);
    idle(200);
    compare_queues("same_edge");
    check("same_edge_data", rx_data, 8'hFF);
    check("same_edge_valid", rx_valid, 1);

    // Reset in the middle of bit 3 of 0xFF, then a clean 0x5A.
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLK - 1) @(negedge clk);
    @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLK + BIT_CLK / 2 - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_rx_data", rx_data, 0);
    check("midreset_rx_valid", rx_valid, 0);
    check("midreset_frame_err", frame_err, 0);
    check("midreset_overrun", overrun, 0);
    rst = 1'b0;
    model_held = 1'b0;
    idle(8 * BIT_CLK);
    compare_queues("aborted");
    send_frame(8'h5A, 1'b1);
    model_frame(last_e0, 8'h5A, 1'b1, 1'b0);
    idle(200);
    compare_queues("after_reset");
    check("after_reset_data", rx_data, 8'h5A);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    model_held = 1'b0;
    idle(20);

    // Random frames, mixed stop errors and gaps down to back-to-back.
    for (int f = 0; f < 12; f++) begin
      d   = 8'($urandom);
      ok  = ($urandom_range(0, 4) != 0);
      gap = $urandom_range(0, 40);
      if (!ok && gap < 20) gap = 20;
      send_frame(d, ok);
      model_frame(last_e0, d, ok, 1'b1);
      if (gap > 0) idle(gap);
    end
    idle(1000);
    compare_queues("random");
    check("random_valid_idle", rx_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
